updown_evt_sched: RTL and testbench
===================================

Name: updown_evt_sched

Overview:
- Upstream event scheduler for the up/down occupancy counter.
- Converts two asynchronous event lines (increment, decrement) into clean, single-cycle, mutually exclusive Up/Down pulses.
- Queues events that arrive while output is stalled or contended, in per-direction pending counters.
- Outputs drive the counter's Up/Down inputs directly; Pwr_off is shared with the counter.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per event input (≥2).
- P_W, 4, width of each pending counter; saturation at 2^P_W-1.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Pwr_off  in  1  synchronous clear, active-high; same effect and priority as Rst.
- Inc_evt  in  1  asynchronous increment request; each rising edge is one event.
- Dec_evt  in  1  asynchronous decrement request; each rising edge is one event.
- Stall  in  1  synchronous; high = emit no pulses, keep queuing.
- Up  out  1  registered one-cycle increment pulse to counter.
- Down  out  1  registered one-cycle decrement pulse to counter.
- Inc_pend  out  P_W  pending increment events.
- Dec_pend  out  P_W  pending decrement events.
- Ovf  out  1  sticky; event dropped due to saturation.
- Busy  out  1  Inc_pend!=0 | Dec_pend!=0 | Up | Down.

Behaviour:
- Reset/power-off (Rst|Pwr_off at an edge): sync chains, edge-detect flops, Inc_pend, Dec_pend, Up, Down, Ovf, priority pointer all cleared to 0. Pointer 0 = Up preferred. Takes priority over all other activity, mid-queue included; queued events are discarded.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - An event is detected when the last stage = 1 and its delayed copy = 0.
  - A sustained high is one event.
  - Minimum resolvable spacing: 2 cycles.
- Pending update each cycle, per direction: next = pend + (edge ? 1 : 0) - (grant ? 1 : 0).
  - Edge and grant in the same cycle: no change.
  - At 2^P_W-1, an edge without a grant is dropped and sets Ovf. Ovf is cleared only by Rst/Pwr_off.
- Grant selection (combinational, from current pending; incoming edges are not visible until the next cycle):
  - Stall=1: no grant.
  - Only Inc_pend!=0: grant Up.
  - Only Dec_pend!=0: grant Down.
  - Both nonzero: grant per pointer. The pointer toggles after each contended grant only, so contended grants alternate Up, Down, Up, ...
- Up/Down are registered copies of the grants and are never both 1.
- Latency, input high before edge 1 with idle queue and no stall: Inc_pend=1 after edge SYNC_STAGES+1, Up=1 after edge SYNC_STAGES+2, for exactly one cycle.
- Stall released: first pulse appears after the next edge.
- Throughput: one pulse per cycle maximum.

Optional Feature:
- Macro UPDOWN_CANCEL_EN.
- Defined: when both pendings are nonzero and Stall=0, both decrement by 1 and no pulse is emitted (net-zero cancellation). The pointer is unused and held at 0.
- Undefined: alternating grants as above.
- Single-direction behaviour is identical in both builds.

Test Plan (SYNC_STAGES=2, P_W=4):
- Single Inc_evt pulse of 3 cycles from idle -> Inc_pend 0→1→0; Up=1 for exactly one cycle, 4 edges after input rise; Down stays 0; Busy falls the cycle after Up.
- Stall=1; 3 Inc and 2 Dec events; then Stall=0 -> with macro undefined: Up,Down,Up,Down,Up on 5 consecutive cycles. With UPDOWN_CANCEL_EN: 2 idle cycles with pendings 3/2→2/1→1/0, then Up once.
- Stall=1; 16 Inc events -> Inc_pend saturates at 15 on event 15; event 16 sets Ovf=1. Stall=0 -> exactly 15 Up pulses; Ovf stays 1.
- Inc_pend=2, Stall=0, new Inc edge in the same cycle as a grant -> Inc_pend holds 2 that cycle; total 3 Up pulses.
- Rst (then separately Pwr_off) asserted with Inc_pend=5, Dec_pend=3 -> after the edge all outputs 0, Ovf=0. Subsequent single Inc event yields Up with the normal 4-cycle latency.
- Inc_evt held high 20 cycles -> exactly one Up pulse.

Source files
------------

// File: rtl/updown_evt_sched.sv
// Up/down event scheduler: synchronizes Inc/Dec events and queues them per direction.
// It emits single-cycle, mutually exclusive Up/Down pulses. Define UPDOWN_CANCEL_EN to net-cancel contended pairs.
module updown_evt_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int P_W         = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Pwr_off,
  input  logic           Inc_evt,
  input  logic           Dec_evt,
  input  logic           Stall,
  output logic           Up,
  output logic           Down,
  output logic [P_W-1:0] Inc_pend,
  output logic [P_W-1:0] Dec_pend,
  output logic           Ovf,
  output logic           Busy
);

  localparam logic [P_W-1:0] PMAX = '1;
  localparam logic [P_W-1:0] PONE = {{(P_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_inc_sync, r_dec_sync;
  logic                   r_inc_dly, r_dec_dly;
  logic [P_W-1:0]         r_inc_pend, r_dec_pend;
  logic                   r_up, r_dn, r_ovf, r_ptr;

  logic           w_clr;
  logic           w_inc_edge, w_dec_edge;
  logic           w_inc_nz, w_dec_nz;
  logic           w_gnt_up, w_gnt_dn;
  logic           w_take_inc, w_take_dec;
  logic           w_ptr_nxt;
  logic [P_W-1:0] w_inc_pend_nxt, w_dec_pend_nxt;
  logic           w_inc_drop, w_dec_drop;

  assign w_clr      = Rst | Pwr_off;
  assign w_inc_edge = r_inc_sync[SYNC_STAGES-1] & ~r_inc_dly;
  assign w_dec_edge = r_dec_sync[SYNC_STAGES-1] & ~r_dec_dly;
  assign w_inc_nz   = |r_inc_pend;
  assign w_dec_nz   = |r_dec_pend;

  // Grants look only at the registered pending counts, never at this cycle's edges.
  always_comb begin
    w_gnt_up   = 1'b0;
    w_gnt_dn   = 1'b0;
    w_take_inc = 1'b0;
    w_take_dec = 1'b0;
    w_ptr_nxt  = r_ptr;
    if (!Stall) begin
      if (w_inc_nz && w_dec_nz) begin
`ifdef UPDOWN_CANCEL_EN
        w_take_inc = 1'b1;
        w_take_dec = 1'b1;
        w_ptr_nxt  = 1'b0;
`else
        if (!r_ptr) begin
          w_gnt_up   = 1'b1;
          w_take_inc = 1'b1;
        end else begin
          w_gnt_dn   = 1'b1;
          w_take_dec = 1'b1;
        end
        w_ptr_nxt = ~r_ptr;
`endif
      end else if (w_inc_nz) begin
        w_gnt_up   = 1'b1;
        w_take_inc = 1'b1;
      end else if (w_dec_nz) begin
        w_gnt_dn   = 1'b1;
        w_take_dec = 1'b1;
      end
    end
  end

  always_comb begin
    w_inc_pend_nxt = r_inc_pend;
    w_dec_pend_nxt = r_dec_pend;
    w_inc_drop     = 1'b0;
    w_dec_drop     = 1'b0;
    if (w_inc_edge && !w_take_inc) begin
      if (r_inc_pend == PMAX) w_inc_drop = 1'b1;
      else                    w_inc_pend_nxt = r_inc_pend + PONE;
    end else if (!w_inc_edge && w_take_inc) begin
      w_inc_pend_nxt = r_inc_pend - PONE;
    end
    if (w_dec_edge && !w_take_dec) begin
      if (r_dec_pend == PMAX) w_dec_drop = 1'b1;
      else                    w_dec_pend_nxt = r_dec_pend + PONE;
    end else if (!w_dec_edge && w_take_dec) begin
      w_dec_pend_nxt = r_dec_pend - PONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_clr) begin
      r_inc_sync <= '0;
      r_dec_sync <= '0;
      r_inc_dly  <= 1'b0;
      r_dec_dly  <= 1'b0;
      r_inc_pend <= '0;
      r_dec_pend <= '0;
      r_up       <= 1'b0;
      r_dn       <= 1'b0;
      r_ovf      <= 1'b0;
      r_ptr      <= 1'b0;
    end else begin
      r_inc_sync <= {r_inc_sync[SYNC_STAGES-2:0], Inc_evt};
      r_dec_sync <= {r_dec_sync[SYNC_STAGES-2:0], Dec_evt};
      r_inc_dly  <= r_inc_sync[SYNC_STAGES-1];
      r_dec_dly  <= r_dec_sync[SYNC_STAGES-1];
      r_inc_pend <= w_inc_pend_nxt;
      r_dec_pend <= w_dec_pend_nxt;
      r_up       <= w_gnt_up;
      r_dn       <= w_gnt_dn;
      r_ovf      <= r_ovf | w_inc_drop | w_dec_drop;
      r_ptr      <= w_ptr_nxt;
    end
  end

  assign Up       = r_up;
  assign Down     = r_dn;
  assign Inc_pend = r_inc_pend;
  assign Dec_pend = r_dec_pend;
  assign Ovf      = r_ovf;
  assign Busy     = w_inc_nz | w_dec_nz | r_up | r_dn;

endmodule

// File: tb/tb_updown_evt_sched.sv
// Scoreboard bench for updown_evt_sched: expected pulses (direction + cycle) are queued by stimulus.
// A negedge monitor pops the queue and compares each pulse against the DUT.
module tb_updown_evt_sched;

  logic       Clk = 1'b0;
  logic       Rst, Pwr_off, Inc_evt, Dec_evt, Stall;
  logic       Up, Down, Ovf, Busy;
  logic [3:0] Inc_pend, Dec_pend;

  updown_evt_sched #(.SYNC_STAGES(2), .P_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Inc_evt(Inc_evt), .Dec_evt(Dec_evt),
    .Stall(Stall), .Up(Up), .Down(Down), .Inc_pend(Inc_pend), .Dec_pend(Dec_pend),
    .Ovf(Ovf), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {bit up; int at;} exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_pulse(input bit up, input int at);
    exp_t e;
    e.up = up;
    e.at = at;
    q.push_back(e);
  endtask

  // Two cycles high, two low: meets the minimum spacing, pend is updated by the end.
  task automatic evt(input bit inc, input bit dec);
    Inc_evt = inc;
    Dec_evt = dec;
    ticks(2);
    Inc_evt = 1'b0;
    Dec_evt = 1'b0;
    ticks(2);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_up"}, Up, 0);
    chk({nm, "_down"}, Down, 0);
    chk({nm, "_inc_pend"}, Inc_pend, 0);
    chk({nm, "_dec_pend"}, Dec_pend, 0);
    chk({nm, "_ovf"}, Ovf, 0);
    chk({nm, "_busy"}, Busy, 0);
  endtask

  always @(negedge Clk) begin : mon
    exp_t e;
    if (Up || Down) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got up=%0d down=%0d at cyc %0d expected no pulse", Up, Down, cyc);
      end else begin
        e = q.pop_front();
        if (Up != e.up || Down != !e.up || cyc != e.at) begin
          bad++;
          $display("FAIL pulse: got up=%0d down=%0d at cyc %0d expected up=%0d down=%0d at cyc %0d",
                   Up, Down, cyc, e.up, !e.up, e.at);
        end
      end
    end
  end

  initial begin
    int c;
    int s;
    Rst = 1'b1; Pwr_off = 1'b0; Inc_evt = 1'b0; Dec_evt = 1'b0; Stall = 1'b0;
    ticks(2);
    chk_idle("reset");
    Rst = 1'b0;
    tick();

    // Single 3-cycle Inc pulse from idle.
    c = cyc;
    Inc_evt = 1'b1;
    expect_pulse(1'b1, c + 4);
    ticks(3);
    chk("t1_pend_one", Inc_pend, 1);
    Inc_evt = 1'b0;
    tick();
    chk("t1_pend_zero", Inc_pend, 0);
    chk("t1_up", Up, 1);
    chk("t1_down", Down, 0);
    chk("t1_busy_hi", Busy, 1);
    tick();
    chk("t1_busy_lo", Busy, 0);
    chk("t1_up_lo", Up, 0);

    // Stalled 3 Inc + 2 Dec, then release.
    Stall = 1'b1;
    evt(1'b1, 1'b1);
    evt(1'b1, 1'b1);
    evt(1'b1, 1'b0);
    chk("t2_inc_pend", Inc_pend, 3);
    chk("t2_dec_pend", Dec_pend, 2);
    s = cyc;
    Stall = 1'b0;
`ifdef UPDOWN_CANCEL_EN
    expect_pulse(1'b1, s + 3);
    tick();
    chk("t2c_inc_a", Inc_pend, 2);
    chk("t2c_dec_a", Dec_pend, 1);
    tick();
    chk("t2c_inc_b", Inc_pend, 1);
    chk("t2c_dec_b", Dec_pend, 0);
    ticks(4);
`else
    expect_pulse(1'b1, s + 1);
    expect_pulse(1'b0, s + 2);
    expect_pulse(1'b1, s + 3);
    expect_pulse(1'b0, s + 4);
    expect_pulse(1'b1, s + 5);
    ticks(6);
`endif
    chk("t2_inc_drained", Inc_pend, 0);
    chk("t2_dec_drained", Dec_pend, 0);

    // Saturation: 16 stalled Inc events, then drain.
    Stall = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      evt(1'b1, 1'b0);
      if (i == 15) begin
        chk("t3_sat15", Inc_pend, 15);
        chk("t3_ovf_lo", Ovf, 0);
      end
      if (i == 16) begin
        chk("t3_sat16", Inc_pend, 15);
        chk("t3_ovf_hi", Ovf, 1);
      end
    end
    s = cyc;
    Stall = 1'b0;
    for (int k = 1; k <= 15; k++) expect_pulse(1'b1, s + k);
    ticks(17);
    chk("t3_ovf_sticky", Ovf, 1);
    chk("t3_drained", Inc_pend, 0);

    // Clear with Rst, then with Pwr_off, from a 5/3 queue.
    for (int m = 0; m < 2; m++) begin
      Stall = 1'b1;
      evt(1'b1, 1'b1);
      evt(1'b1, 1'b1);
      evt(1'b1, 1'b1);
      evt(1'b1, 1'b0);
      evt(1'b1, 1'b0);
      chk(m == 0 ? "t5r_inc5" : "t5p_inc5", Inc_pend, 5);
      chk(m == 0 ? "t5r_dec3" : "t5p_dec3", Dec_pend, 3);
      if (m == 0) Rst = 1'b1;
      else        Pwr_off = 1'b1;
      tick();
      chk_idle(m == 0 ? "t5r" : "t5p");
      Rst = 1'b0;
      Pwr_off = 1'b0;
      Stall = 1'b0;
      c = cyc;
      Inc_evt = 1'b1;
      expect_pulse(1'b1, c + 4);
      ticks(2);
      Inc_evt = 1'b0;
      ticks(4);
      chk(m == 0 ? "t5r_after" : "t5p_after", Busy, 0);
    end

    // New Inc edge lands in the same cycle as a grant with Inc_pend=2.
    Stall = 1'b1;
    evt(1'b1, 1'b0);
    evt(1'b1, 1'b0);
    chk("t4_pend2", Inc_pend, 2);
    Inc_evt = 1'b1;
    ticks(2);
    Stall = 1'b0;
    s = cyc;
    expect_pulse(1'b1, s + 1);
    expect_pulse(1'b1, s + 2);
    expect_pulse(1'b1, s + 3);
    tick();
    chk("t4_hold2", Inc_pend, 2);
    chk("t4_up", Up, 1);
    Inc_evt = 1'b0;
    tick();
    chk("t4_pend1", Inc_pend, 1);
    tick();
    chk("t4_pend0", Inc_pend, 0);
    ticks(3);

    // Sustained high is a single event.
    c = cyc;
    Inc_evt = 1'b1;
    expect_pulse(1'b1, c + 4);
    ticks(20);
    Inc_evt = 1'b0;
    ticks(6);
    chk("t6_idle", Busy, 0);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
